// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller: 16-state TAP FSM, 8-bit IR, bypass bit, decode of the
// IR into strobes for the SC01, IMEM and boundary-scan chains, and a
// falling-edge registered, tri-stated TDO.
module jtag_tap_ctrl #(
  parameter int              IR_W       = 8,
  parameter logic [IR_W-1:0] OP_IMEM    = 8'h80,
  parameter logic [IR_W-1:0] OP_SC01    = 8'h81,
  parameter logic [IR_W-1:0] OP_EXTEST  = 8'h00,
  parameter logic [IR_W-1:0] OP_SAMPLE  = 8'h01,
  parameter logic [IR_W-1:0] OP_BYPASS  = 8'hFF,
  parameter logic [IR_W-1:0] IR_CAPTURE = 8'h0F
) (
  input  logic tck_i,
  input  logic trst_i,
  input  logic tms_i,
  input  logic tdi_i,
  output logic tdo_o,
  output logic tap_rst_o,
  input  logic sc01_tdo_i,
  output logic sc01_tdi_o,
  output logic sc01_shift_o,
  output logic sc01_clock_o,
  input  logic im_tdo_i,
  output logic im_tdi_o,
  output logic im_shift_o,
  output logic im_clock_o,
  output logic im_upd_o,
  output logic im_mode_o,
  input  logic bs_tdo_i,
  output logic bs_tdi_o,
  output logic bs_shift_o,
  output logic bs_clock_o,
  output logic bs_upd_o,
  output logic bs_mode_o
);

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
  } tap_state_e;

  tap_state_e      state;
  logic [IR_W-1:0] ir_shift;
  logic [IR_W-1:0] ir;
  logic            bypass;
  logic            tdo_q;
  logic            tdo_en;
  logic            dr_tdo;

  logic in_tlr, cap_dr, shift_dr, upd_dr, shift_ir;
  logic sel_sc01, sel_im, sel_bs;

  assign in_tlr   = (state == TLR);
  assign cap_dr   = (state == CAP_DR);
  assign shift_dr = (state == SHIFT_DR);
  assign upd_dr   = (state == UPD_DR);
  assign shift_ir = (state == SHIFT_IR);

  assign sel_sc01 = (ir == OP_SC01);
  assign sel_im   = (ir == OP_IMEM);
  assign sel_bs   = (ir == OP_EXTEST) || (ir == OP_SAMPLE);

  // TAP state machine; tms sequences walk the standard 1149.1 graph
  always_ff @(posedge tck_i) begin
    if (!trst_i) begin
      state <= TLR;
    end else begin
      unique case (state)
        TLR:      state <= tms_i ? TLR      : RTI;
        RTI:      state <= tms_i ? SEL_DR   : RTI;
        SEL_DR:   state <= tms_i ? SEL_IR   : CAP_DR;
        CAP_DR:   state <= tms_i ? EXIT1_DR : SHIFT_DR;
        SHIFT_DR: state <= tms_i ? EXIT1_DR : SHIFT_DR;
        EXIT1_DR: state <= tms_i ? UPD_DR   : PAUSE_DR;
        PAUSE_DR: state <= tms_i ? EXIT2_DR : PAUSE_DR;
        EXIT2_DR: state <= tms_i ? UPD_DR   : SHIFT_DR;
        UPD_DR:   state <= tms_i ? SEL_DR   : RTI;
        SEL_IR:   state <= tms_i ? TLR      : CAP_IR;
        CAP_IR:   state <= tms_i ? EXIT1_IR : SHIFT_IR;
        SHIFT_IR: state <= tms_i ? EXIT1_IR : SHIFT_IR;
        EXIT1_IR: state <= tms_i ? UPD_IR   : PAUSE_IR;
        PAUSE_IR: state <= tms_i ? EXIT2_IR : PAUSE_IR;
        EXIT2_IR: state <= tms_i ? UPD_IR   : SHIFT_IR;
        UPD_IR:   state <= tms_i ? SEL_DR   : RTI;
        default:  state <= TLR;
      endcase
    end
  end

  // IR shift/capture path and the active instruction, which only changes on leaving UpdIR
  always_ff @(posedge tck_i) begin
    if (!trst_i) begin
      ir_shift <= IR_CAPTURE;
      ir       <= OP_BYPASS;
    end else begin
      if (state == CAP_IR)
        ir_shift <= IR_CAPTURE;
      else if (shift_ir)
        ir_shift <= {tdi_i, ir_shift[IR_W-1:1]};
      if (in_tlr)
        ir <= OP_BYPASS;
      else if (state == UPD_IR)
        ir <= ir_shift;
    end
  end

  // Bypass bit: captures 0, then gives a one-TCK tdi-to-tdo path
  always_ff @(posedge tck_i) begin
    if (!trst_i)
      bypass <= 1'b0;
    else if (cap_dr)
      bypass <= 1'b0;
    else if (shift_dr)
      bypass <= tdi_i;
  end

  // Serial return of the selected data register; undefined opcodes fall to bypass
  always_comb begin
    dr_tdo = bypass;
    if (sel_sc01)    dr_tdo = sc01_tdo_i;
    else if (sel_im) dr_tdo = im_tdo_i;
    else if (sel_bs) dr_tdo = bs_tdo_i;
  end

  // TDO launched on the falling edge so the receiver samples a stable bit on the rising edge
  always_ff @(negedge tck_i) begin
    tdo_en <= shift_ir | shift_dr;
    tdo_q  <= shift_ir ? ir_shift[0] : dr_tdo;
  end

  assign tdo_o     = tdo_en ? tdo_q : 1'bz;
  assign tap_rst_o = ~in_tlr;

  assign sc01_tdi_o = tdi_i;
  assign im_tdi_o   = tdi_i;
  assign bs_tdi_o   = tdi_i;

  // SC01 clock select drops outside Cap/Shift so the functional clock owns the chain
  assign sc01_shift_o = sel_sc01 & shift_dr;
  assign sc01_clock_o = sel_sc01 & (cap_dr | shift_dr);

  assign im_shift_o = sel_im & shift_dr;
  assign im_clock_o = sel_im & (cap_dr | shift_dr);
  assign im_upd_o   = sel_im & upd_dr;
  assign im_mode_o  = sel_im & ~in_tlr;

  assign bs_shift_o = sel_bs & shift_dr;
  assign bs_clock_o = sel_bs & (cap_dr | shift_dr);
  assign bs_upd_o   = sel_bs & upd_dr;
  assign bs_mode_o  = (ir == OP_EXTEST) & ~in_tlr;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Scoreboard bench for jtag_tap_ctrl: the driver applies one TCK vector at a
// time, advances an abstract TAP model and queues the expected outputs; the
// monitor pops one entry per falling edge and compares.
module tb_jtag_tap_ctrl;

  logic tck = 1'b0;
  logic trst_i = 1'b0, tms_i = 1'b1, tdi_i = 1'b0;
  logic sc01_tdo_i = 1'b0, im_tdo_i = 1'b0, bs_tdo_i = 1'b0;
  logic tdo_o, tap_rst_o;
  logic sc01_tdi_o, sc01_shift_o, sc01_clock_o;
  logic im_tdi_o, im_shift_o, im_clock_o, im_upd_o, im_mode_o;
  logic bs_tdi_o, bs_shift_o, bs_clock_o, bs_upd_o, bs_mode_o;

  jtag_tap_ctrl dut (
    .tck_i(tck), .trst_i(trst_i), .tms_i(tms_i), .tdi_i(tdi_i), .tdo_o(tdo_o),
    .tap_rst_o(tap_rst_o),
    .sc01_tdo_i(sc01_tdo_i), .sc01_tdi_o(sc01_tdi_o), .sc01_shift_o(sc01_shift_o),
    .sc01_clock_o(sc01_clock_o),
    .im_tdo_i(im_tdo_i), .im_tdi_o(im_tdi_o), .im_shift_o(im_shift_o),
    .im_clock_o(im_clock_o), .im_upd_o(im_upd_o), .im_mode_o(im_mode_o),
    .bs_tdo_i(bs_tdo_i), .bs_tdi_o(bs_tdi_o), .bs_shift_o(bs_shift_o),
    .bs_clock_o(bs_clock_o), .bs_upd_o(bs_upd_o), .bs_mode_o(bs_mode_o)
  );

  always #5 tck = ~tck;

  // Abstract model: a phase plus which side (DR/IR) of the graph we are on
  localparam int P_TLR = 0, P_RTI = 1, P_SEL = 2, P_CAP = 3, P_SHIFT = 4,
                 P_EXIT1 = 5, P_PAUSE = 6, P_EXIT2 = 7, P_UPD = 8;
  int         ph = P_TLR;
  bit         dr = 1'b1;
  logic [7:0] m_ir = 8'hFF;
  logic [7:0] m_sr = 8'h00;
  bit         m_byp = 1'b0;

  typedef struct {
    logic        tdo;
    logic [13:0] stb;
  } exp_t;
  exp_t q[$];

  int vectors = 0;
  int miscompares = 0;
  int vec_id = 0;

  task automatic step_r(input bit tms, input bit tdi, input bit rst_n);
    exp_t e;
    bit sc, im, bs, ex, tl, cap, sh, up;
    @(negedge tck); #3;
    tms_i = tms; tdi_i = tdi; trst_i = rst_n;
    sc01_tdo_i = $urandom_range(0, 1);
    im_tdo_i   = $urandom_range(0, 1);
    bs_tdo_i   = $urandom_range(0, 1);
    if (!rst_n) begin
      ph = P_TLR; m_ir = 8'hFF;
    end else begin
      if (ph == P_TLR) m_ir = 8'hFF;
      if (!dr && ph == P_CAP)   m_sr = 8'h0F;
      if (!dr && ph == P_SHIFT) m_sr = (m_sr >> 1) | (8'(tdi) << 7);
      if (!dr && ph == P_UPD)   m_ir = m_sr;
      if (dr && ph == P_CAP)    m_byp = 1'b0;
      if (dr && ph == P_SHIFT)  m_byp = tdi;
      case (ph)
        P_TLR:   ph = tms ? P_TLR : P_RTI;
        P_RTI:   if (tms) begin ph = P_SEL; dr = 1'b1; end
        P_SEL:   if (!tms) ph = P_CAP; else if (dr) dr = 1'b0; else ph = P_TLR;
        P_CAP:   ph = tms ? P_EXIT1 : P_SHIFT;
        P_SHIFT: ph = tms ? P_EXIT1 : P_SHIFT;
        P_EXIT1: ph = tms ? P_UPD : P_PAUSE;
        P_PAUSE: ph = tms ? P_EXIT2 : P_PAUSE;
        P_EXIT2: ph = tms ? P_UPD : P_SHIFT;
        default: if (tms) begin ph = P_SEL; dr = 1'b1; end else ph = P_RTI;
      endcase
    end
    sc = (m_ir == 8'h81);
    im = (m_ir == 8'h80);
    bs = (m_ir == 8'h00) || (m_ir == 8'h01);
    ex = (m_ir == 8'h00);
    tl  = (ph == P_TLR);
    cap = dr && ph == P_CAP;
    sh  = dr && ph == P_SHIFT;
    up  = dr && ph == P_UPD;
    if (ph == P_SHIFT && !dr) e.tdo = m_sr[0];
    else if (sh)              e.tdo = sc ? sc01_tdo_i : im ? im_tdo_i : bs ? bs_tdo_i : m_byp;
    else                      e.tdo = 1'bz;
    e.stb = {!tl, tdi, sc & sh, sc & (cap | sh), tdi, im & sh, im & (cap | sh), im & up,
             im & !tl, tdi, bs & sh, bs & (cap | sh), bs & up, ex & !tl};
    q.push_back(e);
  endtask

  task automatic step(input bit tms, input bit tdi);
    step_r(tms, tdi, 1'b1);
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  // From RTI: load an opcode, back in RTI afterwards
  task automatic ir_scan(input logic [7:0] v);
    step(1, rb()); step(1, rb()); step(0, rb()); step(0, rb());
    for (int i = 0; i < 8; i++) step(i == 7, v[i]);
    step(1, rb()); step(0, rb());
  endtask

  // From RTI: n-bit DR scan, optionally detouring through PauseDR after pause_after bits
  task automatic dr_scan(input logic [127:0] data, input int n, input int pause_after);
    step(1, rb()); step(0, rb()); step(0, rb());
    for (int i = 0; i < n; i++) begin
      bit last, pz;
      last = (i == n - 1);
      pz = (pause_after > 0) && (i == pause_after - 1) && !last;
      step(last || pz, data[i]);
      if (pz) begin step(0, rb()); step(0, rb()); step(1, rb()); step(0, rb()); end
    end
    step(1, rb()); step(0, rb());
  endtask

  task automatic to_rti();
    for (int i = 0; i < 5; i++) step(1, rb());
    step(0, rb());
  endtask

  // Monitor: one expected entry per falling edge, sampled after TDO has launched
  initial begin
    exp_t e;
    forever begin
      @(negedge tck); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        vec_id++;
        vectors++;
        if (tdo_o !== e.tdo) begin
          miscompares++;
          $display("FAIL tdo vec %0d: got %b want %b", vec_id, tdo_o, e.tdo);
        end
        vectors++;
        if ({tap_rst_o, sc01_tdi_o, sc01_shift_o, sc01_clock_o, im_tdi_o, im_shift_o,
             im_clock_o, im_upd_o, im_mode_o, bs_tdi_o, bs_shift_o, bs_clock_o,
             bs_upd_o, bs_mode_o} !== e.stb) begin
          miscompares++;
          $display("FAIL strobes vec %0d: got %b want %b", vec_id,
                   {tap_rst_o, sc01_tdi_o, sc01_shift_o, sc01_clock_o, im_tdi_o,
                    im_shift_o, im_clock_o, im_upd_o, im_mode_o, bs_tdi_o, bs_shift_o,
                    bs_clock_o, bs_upd_o, bs_mode_o}, e.stb);
        end
      end
    end
  end

  initial begin
    logic [127:0] d;
    logic [7:0] ops [6];
    ops[0] = 8'h80; ops[1] = 8'h81; ops[2] = 8'h00;
    ops[3] = 8'h01; ops[4] = 8'hFF; ops[5] = 8'h3C;

    // Reset held for two TCK, then TLR and RTI
    step_r(1, 0, 0); step_r(1, 0, 0);
    step(1, 0); step(0, 0);

    // Capture value comes out LSB-first; shifting ones keeps the IR at bypass
    ir_scan(8'hFF);
    d = 128'b01010;
    dr_scan(d, 5, 0);

    // SC01 with a pause mid-scan
    ir_scan(8'h81);
    d = 128'b1001;
    dr_scan(d, 4, 2);

    // IMEM long chain
    ir_scan(8'h80);
    d = 128'h0a5a5a5a5a5a5a;
    dr_scan(d, 97, 0);

    // Boundary scan: EXTEST vs SAMPLE
    ir_scan(8'h00);
    d = {$urandom, $urandom, $urandom, $urandom};
    dr_scan(d, 8, 3);
    ir_scan(8'h01);
    d = {$urandom, $urandom, $urandom, $urandom};
    dr_scan(d, 8, 0);

    // Five tms=1 from ShiftDR reach TLR with all strobes low
    step(1, 1); step(0, 1); step(0, 0); step(0, 1); step(0, 0);
    for (int i = 0; i < 5; i++) step(1, rb());
    step(0, rb());

    // Reset mid IR shift discards the partial opcode; IR returns to bypass
    ir_scan(8'h81);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0); step(0, 0); step(0, 0);
    step_r(0, 0, 0);
    step(1, 0); step(0, 0);
    d = {$urandom, $urandom, $urandom, $urandom};
    dr_scan(d, 6, 0);

    // Undefined opcode decodes as bypass
    ir_scan(8'h5A);
    d = {$urandom, $urandom, $urandom, $urandom};
    dr_scan(d, 6, 2);

    // Random opcode/length scans
    for (int k = 0; k < 10; k++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      ir_scan(ops[$urandom_range(0, 5)]);
      dr_scan(d, $urandom_range(1, 40), $urandom_range(0, 6));
    end

    // Random walk across the whole graph, with occasional resets
    for (int k = 0; k < 400; k++)
      step_r(($urandom_range(0, 9) < 3), rb(), ($urandom_range(0, 59) != 0));
    to_rti();

    @(negedge tck); #2;
    @(negedge tck); #2;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/jtag_tap_ctrl.md
Name: jtag_tap_ctrl

Overview:
- IEEE 1149.1-style TAP controller with an 8-bit instruction register (IR) and a 1-bit bypass register.
- Decodes the IR into control strobes for three external data-register chains: the SC01 scan chain, the IMEM chain (97-bit dr_reg) and the boundary-scan chain (BS).
- Muxes the selected serial output to a tri-stated TDO.
- Sits between the chip-level JTAG pins and the on-chip test chains.

Parameters:
- IR_W, 8, instruction register width.
- OP_IMEM, 8'h80, selects the IMEM chain.
- OP_SC01, 8'h81, selects the SC01 scan chain.
- OP_EXTEST, 8'h00, selects BS in test mode.
- OP_SAMPLE, 8'h01, selects BS in sample/preload mode.
- OP_BYPASS, 8'hFF, bypass; any undefined opcode also decodes as bypass.
- IR_CAPTURE, 8'h0F, value loaded into the IR shift register in Capture-IR.

Ports:
- tck_i  in  1  TCK; the only clock.
- trst_i  in  1  synchronous, active-low reset.
- tms_i  in  1  test mode select.
- tdi_i  in  1  test data in.
- tdo_o  out  1  test data out; high-Z when not shifting.
- tap_rst_o  out  1  active-low chain reset; low while in Test-Logic-Reset.
- sc01_tdo_i  in  1  serial return from SC01.
- sc01_tdi_o, sc01_shift_o, sc01_clock_o  out  1 each  SC01 serial in, shift enable, TCK-select.
- im_tdo_i  in  1  serial return from IMEM.
- im_tdi_o, im_shift_o, im_clock_o, im_upd_o, im_mode_o  out  1 each  IMEM serial in, shift, clock enable, update, mode.
- bs_tdo_i  in  1  serial return from BS.
- bs_tdi_o, bs_shift_o, bs_clock_o, bs_upd_o, bs_mode_o  out  1 each  BS serial in, shift, clock enable, update, mode.

Behaviour:
- Reset and clocking:
  - All state updates on rising tck_i.
  - trst_i=0 sampled on a rising edge: state goes to Test-Logic-Reset (TLR) and the IR goes to OP_BYPASS.
  - Reset is synchronous only; no asynchronous path.
- TAP FSM: 16 states, transitions on rising edge. Each state lists its next state as tms=0 / tms=1:
  - TLR: RTI / TLR.
  - RTI: RTI / SelDR.
  - SelDR: CapDR / SelIR.
  - SelIR: CapIR / TLR.
  - CapXR: ShiftXR / Exit1XR.
  - ShiftXR: ShiftXR / Exit1XR.
  - Exit1XR: PauseXR / UpdXR.
  - PauseXR: PauseXR / Exit2XR.
  - Exit2XR: ShiftXR / UpdXR.
  - UpdXR: RTI / SelDR.
  - Five consecutive tms=1 edges reach TLR from any state.
- IR:
  - CapIR loads IR_CAPTURE into the shift register.
  - Each ShiftIR edge shifts right, with tdi_i into the MSB.
  - The instruction register latches the shift register on the rising edge that leaves UpdIR.
  - TLR forces the instruction register to OP_BYPASS.
- Bypass:
  - CapDR loads 0.
  - ShiftDR loads tdi_i.
  - Latency is one TCK from tdi_i to the TDO path.
- TDO:
  - Registered on falling tck_i.
  - Driven only while the state is ShiftIR or ShiftDR; 1'bz otherwise.
  - In ShiftIR, drives IR shift[0].
  - In ShiftDR, drives the selected chain's *_tdo_i, or the bypass bit.
- Serial inputs: sc01_tdi_o, im_tdi_o and bs_tdi_o are all tied combinationally to tdi_i.
- Chain strobes: combinational from the current state and IR.
  - SC01 (IR=OP_SC01):
    - sc01_shift_o = ShiftDR.
    - sc01_clock_o = CapDR | ShiftDR. It is 0 in PauseDR, Exit and Update states so the functional clock owns the chain.
  - IMEM (IR=OP_IMEM):
    - im_clock_o = CapDR | ShiftDR.
    - im_shift_o = ShiftDR.
    - im_upd_o = UpdDR, exactly one TCK per update.
    - im_mode_o = 1 while the opcode is selected.
  - BS (IR=OP_EXTEST or OP_SAMPLE): bs_* strobes follow the IMEM rules; bs_mode_o = 1 only for EXTEST.
  - All strobes are 0 when their opcode is not selected and in TLR.
- Boundary conditions:
  - Reset mid-shift discards partial IR and DR contents.
  - An IR change takes effect only after UpdIR.
  - PauseDR holds all chains, with every shift and clock strobe at 0.

Test Plan:
- trst_i=0 for 2 TCK, then tms=1 → TLR, tdo_o=z, IR=8'hFF, tap_rst_o=0; tms=0 → RTI, tap_rst_o=1.
- IR scan shifting tdi=1 for 8 bits → tdo_o emits 8'h0F LSB-first (1,1,1,1,0,0,0,0), z outside ShiftIR; IR=8'hFF after UpdIR.
- BYPASS DR scan, tdi=0,1,0,1,0 → tdo_o=0 (captured bit), then 0,1,0,1, i.e. one-cycle delay; z in Exit1DR and UpdDR.
- IR=8'h81, shift 2'b01 then PauseDR → sc01_shift_o=1 and sc01_clock_o=1 only in Cap/ShiftDR, both 0 in PauseDR; resume via Exit2DR → ShiftDR returns sc01_tdo_i on tdo_o.
- IR=8'h80, 97-bit shift of 97'ha5a5a5a5a5a5a → im_shift_o high for exactly 97 ShiftDR edges, im_upd_o a single one-TCK pulse in UpdDR, im_mode_o=1.
- IR=8'h00 vs 8'h01 → bs_mode_o=1 vs 0; 5×tms=1 from ShiftDR → TLR, all strobes 0.
